// File: rtl/inverse_key_schedule.sv
// AES key expansion (one word/cycle) streaming round keys NR..0 over valid/ready.
// Define INV_MIXCOL_KEYS_EN to emit equivalent-inverse-cipher keys for rounds 1..NR-1.
`ifndef KEY_SIZE
`define KEY_SIZE 128
`endif

module inverse_key_schedule #(
  parameter int KEY_BITS = `KEY_SIZE
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [127:0]        rk_data,
  output logic [3:0]          rk_round,
  output logic                rk_last
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK_I = 6'(NK);
  localparam logic [5:0] LAST_I = 6'(NW - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("inverse_key_schedule: KEY_BITS must be 128, 192 or 256");
  end

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as x^254 in GF(2^8) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] x3, x7, x15, x31, x63, x127, inv;
    x3   = gf_mul(gf_mul(v, v), v);
    x7   = gf_mul(gf_mul(x3, x3), v);
    x15  = gf_mul(gf_mul(x7, x7), v);
    x31  = gf_mul(gf_mul(x15, x15), v);
    x63  = gf_mul(gf_mul(x31, x31), v);
    x127 = gf_mul(gf_mul(x63, x63), v);
    inv  = gf_mul(x127, x127);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [1:0]  state_reg;
  logic [5:0]  idx_reg;
  logic [2:0]  kmod_reg;
  logic [7:0]  rcon_reg;
  logic [31:0] words [0:NW-1];

  logic [31:0]  prev_word, sub_in, sub_out, temp_word, new_word;
  logic [5:0]   rd_base;
  logic [127:0] stream_key, next_key;

  always_comb begin
    prev_word = words[idx_reg - 6'd1];
    sub_in    = (kmod_reg == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    sub_out   = sub_word(sub_in);
    temp_word = prev_word;
    if (kmod_reg == 3'd0)
      temp_word = sub_out ^ {rcon_reg, 24'h000000};
    else if (NK == 8 && kmod_reg == 3'd4)
      temp_word = sub_out;
    new_word  = words[idx_reg - NK_I] ^ temp_word;
  end

  // Key for round rk_round-1, prepared ahead so the output register loads on transfer.
  assign rd_base    = {rk_round - 4'd1, 2'b00};
  assign stream_key = {words[rd_base], words[rd_base + 6'd1],
                       words[rd_base + 6'd2], words[rd_base + 6'd3]};

`ifdef INV_MIXCOL_KEYS_EN
  logic [127:0] mixed_key;
  for (genvar gi = 0; gi < 4; gi++) begin : g_inv_mix
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = stream_key[32*gi +: 32];
    assign mixed_key[32*gi +: 32] = {
      gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
      gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
      gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
      gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  end
  assign next_key = (rk_round == 4'd1) ? stream_key : mixed_key;
`else
  assign next_key = stream_key;
`endif

  always_ff @(posedge clock) begin
    if (state_reg == IDLE && start) begin
      for (int k = 0; k < NK; k++)
        words[k] <= key[KEY_BITS-1-32*k -: 32];
    end else if (state_reg == EXPAND) begin
      words[idx_reg] <= new_word;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      kmod_reg  <= '0;
      rcon_reg  <= '0;
      rk_valid  <= 1'b0;
      rk_data   <= '0;
      rk_round  <= '0;
      rk_last   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          state_reg <= EXPAND;
          idx_reg   <= NK_I;
          kmod_reg  <= '0;
          rcon_reg  <= 8'h01;
        end
        EXPAND: begin
          kmod_reg <= (kmod_reg == 3'(NK - 1)) ? 3'd0 : kmod_reg + 3'd1;
          if (kmod_reg == 3'd0) rcon_reg <= xtime(rcon_reg);
          if (idx_reg == LAST_I) begin
            // Last word bypasses the store so round NR is ready the cycle after.
            state_reg <= STREAM;
            rk_valid  <= 1'b1;
            rk_data   <= {words[NW-4], words[NW-3], words[NW-2], new_word};
            rk_round  <= 4'(NR);
            rk_last   <= 1'b0;
          end else begin
            idx_reg <= idx_reg + 6'd1;
          end
        end
        STREAM: if (rk_ready) begin
          if (rk_round == 4'd0) begin
            state_reg <= IDLE;
            rk_valid  <= 1'b0;
            rk_last   <= 1'b0;
          end else begin
            rk_round <= rk_round - 4'd1;
            rk_data  <= next_key;
            rk_last  <= (rk_round == 4'd1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_inverse_key_schedule.sv
// Directed bench for inverse_key_schedule (AES-128): latency, order, backpressure, start/reset robustness.
module tb_inverse_key_schedule;
  logic         clock = 1'b0;
  logic         reset, start, rk_ready, busy, rk_valid, rk_last;
  logic [127:0] key, rk_data;
  logic [3:0]   rk_round;
  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;

  always #5 clock = ~clock;

  inverse_key_schedule #(.KEY_BITS(128)) dut (
    .clock(clock), .reset(reset), .start(start), .key(key), .busy(busy),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_round(rk_round), .rk_last(rk_last)
  );

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] imc_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    for (int k = 0; k < 4; k++) begin
      a[k]  = c[31-8*k -: 8];
      m9[k] = xt(xt(xt(a[k]))) ^ a[k];
      mb[k] = xt(xt(xt(a[k]))) ^ xt(a[k]) ^ a[k];
      md[k] = xt(xt(xt(a[k]))) ^ xt(xt(a[k])) ^ a[k];
      me[k] = xt(xt(xt(a[k]))) ^ xt(xt(a[k])) ^ xt(a[k]);
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3], m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3], mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // FIPS-197 A.1 round keys for KEY1.
  function automatic logic [127:0] exp_key1(input int r);
    logic [127:0] raw;
    case (r)
      0:  raw = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      1:  raw = 128'ha0fafe1788542cb123a339392a6c7605;
      2:  raw = 128'hf2c295f27a96b9435935807a7359f67f;
      3:  raw = 128'h3d80477d4716fe3e1e237e446d7a883b;
      4:  raw = 128'hef44a541a8525b7fb671253bdb0bad00;
      5:  raw = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      6:  raw = 128'h6d88a37a110b3efddbf98641ca0093fd;
      7:  raw = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      8:  raw = 128'head27321b58dbad2312bf5607f8d292f;
      9:  raw = 128'hac7766f319fadc2128d12941575c006e;
      10: raw = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      default: raw = '0;
    endcase
`ifdef INV_MIXCOL_KEYS_EN
    if (r >= 1 && r <= 9)
      raw = {imc_col(raw[127:96]), imc_col(raw[95:64]), imc_col(raw[63:32]), imc_col(raw[31:0])};
`endif
    return raw;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k);
    key = k;
    start = 1'b1;
    tick();
    start = 1'b0;
    key = '1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!rk_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; rk_ready = 1'b0; key = '0;
    tick(); tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (rk_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rk_valid); else pass_cnt++;
    total_cnt++; if (rk_last !== 1'b0) $display("FAIL reset_last: got %b want 0", rk_last); else pass_cnt++;
    total_cnt++; if (rk_data !== 128'h0) $display("FAIL reset_data: got %h want 0", rk_data); else pass_cnt++;
    total_cnt++; if (rk_round !== 4'd0) $display("FAIL reset_round: got %0d want 0", rk_round); else pass_cnt++;
    reset = 1'b0;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_fips_stream();
    int n;
    rk_ready = 1'b1;
    do_start(KEY1);
    total_cnt++; if (busy !== 1'b1) $display("FAIL expand_busy: got %b want 1", busy); else pass_cnt++;
    wait_valid(n);
    total_cnt++; if (n != 40) $display("FAIL latency: got %0d want 40 cycles after start edge", n); else pass_cnt++;
    for (int r = 10; r >= 0; r--) begin
      total_cnt++; if (rk_valid !== 1'b1) $display("FAIL s1_valid r%0d: got %b want 1", r, rk_valid); else pass_cnt++;
      total_cnt++; if (rk_round !== 4'(r)) $display("FAIL s1_round: got %0d want %0d", rk_round, r); else pass_cnt++;
      total_cnt++; if (rk_data !== exp_key1(r)) $display("FAIL s1_data r%0d: got %h want %h", r, rk_data, exp_key1(r)); else pass_cnt++;
      total_cnt++; if (rk_last !== (r == 0)) $display("FAIL s1_last r%0d: got %b want %b", r, rk_last, r == 0); else pass_cnt++;
      tick();
    end
    total_cnt++; if (rk_valid !== 1'b0) $display("FAIL s1_end_valid: got %b want 0", rk_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL s1_end_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_second_key();
    int n;
    rk_ready = 1'b1;
    do_start(KEY2);
    wait_valid(n);
    total_cnt++; if (n != 40) $display("FAIL k2_latency: got %0d want 40", n); else pass_cnt++;
    for (int r = 10; r >= 0; r--) begin
      if (r == 10) begin
        total_cnt++;
        if (rk_data !== 128'h13111d7fe3944a17f307a78b4d2b30c5)
          $display("FAIL k2_r10: got %h want 13111d7fe3944a17f307a78b4d2b30c5", rk_data);
        else pass_cnt++;
      end
      if (r == 0) begin
        total_cnt++; if (rk_data !== KEY2) $display("FAIL k2_r0: got %h want %h", rk_data, KEY2); else pass_cnt++;
        total_cnt++; if (rk_last !== 1'b1) $display("FAIL k2_last: got %b want 1", rk_last); else pass_cnt++;
      end
      tick();
    end
    total_cnt++; if (busy !== 1'b0) $display("FAIL k2_end_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int n, exp_r, transfers;
    logic stalled;
    logic [127:0] held;
    rk_ready = 1'b0;
    do_start(KEY1);
    wait_valid(n);
    exp_r = 10; transfers = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 300 && transfers < 11; cyc++) begin
      if (rk_valid) begin
        if (stalled) begin
          total_cnt++; if (rk_data !== held) $display("FAIL bp_stable: got %h want %h", rk_data, held); else pass_cnt++;
        end
        total_cnt++; if (rk_round !== 4'(exp_r)) $display("FAIL bp_round: got %0d want %0d", rk_round, exp_r); else pass_cnt++;
        total_cnt++; if (rk_data !== exp_key1(exp_r)) $display("FAIL bp_data r%0d: got %h want %h", exp_r, rk_data, exp_key1(exp_r)); else pass_cnt++;
        rk_ready = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        stalled = !rk_ready;
        held = rk_data;
        if (rk_ready) begin
          transfers++;
          exp_r--;
        end
      end else begin
        rk_ready = 1'b0;
      end
      tick();
    end
    rk_ready = 1'b0;
    total_cnt++; if (transfers != 11) $display("FAIL bp_count: got %0d want 11", transfers); else pass_cnt++;
    total_cnt++; if (rk_valid !== 1'b0) $display("FAIL bp_end_valid: got %b want 0", rk_valid); else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    int n;
    rk_ready = 1'b1;
    do_start(KEY1);
    repeat (10) tick();
    key = KEY2; start = 1'b1;
    tick();
    start = 1'b0; key = '1;
    wait_valid(n);
    total_cnt++; if (n != 29) $display("FAIL si_latency: got %0d want 29", n); else pass_cnt++;
    for (int r = 10; r >= 0; r--) begin
      total_cnt++; if (rk_data !== exp_key1(r)) $display("FAIL si_data r%0d: got %h want %h", r, rk_data, exp_key1(r)); else pass_cnt++;
      if (r == 5 || r == 0) begin
        key = KEY2; start = 1'b1;
      end
      tick();
      start = 1'b0; key = '1;
    end
    total_cnt++; if (busy !== 1'b0) $display("FAIL si_end_busy: got %b want 0", busy); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL si_idle_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int n;
    rk_ready = 1'b1;
    do_start(KEY1);
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++; if (rk_valid !== 1'b0) $display("FAIL ra_exp_valid: got %b want 0", rk_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL ra_exp_busy: got %b want 0", busy); else pass_cnt++;
    repeat (45) tick();
    total_cnt++; if (rk_valid !== 1'b0) $display("FAIL ra_residual: got %b want 0", rk_valid); else pass_cnt++;
    do_start(KEY1);
    wait_valid(n);
    repeat (3) tick();
    rk_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++; if (rk_valid !== 1'b0) $display("FAIL ra_str_valid: got %b want 0", rk_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL ra_str_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (rk_data !== 128'h0) $display("FAIL ra_str_data: got %h want 0", rk_data); else pass_cnt++;
    rk_ready = 1'b1;
    do_start(KEY1);
    wait_valid(n);
    total_cnt++; if (n != 40) $display("FAIL ra_latency: got %0d want 40", n); else pass_cnt++;
    for (int r = 10; r >= 0; r--) begin
      total_cnt++; if (rk_data !== exp_key1(r)) $display("FAIL ra_data r%0d: got %h want %h", r, rk_data, exp_key1(r)); else pass_cnt++;
      total_cnt++; if (rk_round !== 4'(r)) $display("FAIL ra_round: got %0d want %0d", rk_round, r); else pass_cnt++;
      tick();
    end
    total_cnt++; if (busy !== 1'b0) $display("FAIL ra_end_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fips_stream();
    test_second_key();
    test_backpressure();
    test_start_ignored();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
